// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared constants and state type for the egress arbiter
// Holds the flit width, the header field positions (dest, body length) and the
// arbiter state enum used by noc_egress_arbiter.
package noc_arb_pkg;

    localparam int DWIDTH   = 16;
    localparam int DEST_LSB = 10;
    localparam int DEST_W   = 6;
    localparam int LEN_LSB  = 6;
    localparam int LEN_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DROP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/noc_egress_arbiter_if.sv
// rtl/noc_egress_arbiter_if.sv - flit source and egress sink bundle
// Ports: req_data/req_valid/req_ready (NUM_REQ packed flit sources),
//        out_data/out_valid/out_ready (single egress link).
// slave = arbiter side, master = sources/sink side.
interface noc_egress_arbiter_if #(
    parameter int NUM_REQ = 5,
    parameter int DWIDTH  = 16
);
    logic [NUM_REQ*DWIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DWIDTH-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  req_data, req_valid, out_ready,
        output req_ready, out_data, out_valid
    );

    modport master (
        output req_data, req_valid, out_ready,
        input  req_ready, out_data, out_valid
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder
// Ports: req (request vector), ptr (last winner) -> grant (one-hot),
//        idx (winner index), any (some request present). Combinational.
module rr_pick #(
    parameter  int N  = 5,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] c;

    // Walk from the farthest candidate back to ptr+1 so the closest valid
    // requester after the last winner is the final (winning) assignment.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = '0;
        for (int k = N; k >= 1; k--) begin
            c = IW'((32'(ptr) + 32'(k)) % 32'(N));
            if (req[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = c;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/noc_egress_arbiter.sv
// rtl/noc_egress_arbiter.sv - packet-atomic round-robin egress arbiter
// Ports: ACLK, ARESETn (async active-low), arb_enable (allow new grants),
//        link (slave: req_* sources, out_* registered egress),
//        grant_onehot (current owner), busy (not IDLE),
//        timeout_err (one-cycle pulse when a stalled owner is aborted).
module noc_egress_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int DWIDTH  = noc_arb_pkg::DWIDTH,
    parameter int LEN_LSB = noc_arb_pkg::LEN_LSB,
    parameter int LEN_W   = noc_arb_pkg::LEN_W,
    parameter int TIMEOUT = 64
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                arb_enable,
    noc_egress_arbiter_if.slave link,
    output logic [NUM_REQ-1:0]  grant_onehot,
    output logic                busy,
    output logic                timeout_err
);
    import noc_arb_pkg::*;

    localparam int PW = $clog2(NUM_REQ);
    localparam int SW = $clog2(TIMEOUT);

    arb_state_t          state, state_nx;
    logic [PW-1:0]       ptr, owner;
    logic [LEN_W-1:0]    remaining;
    logic [SW-1:0]       stall_cnt;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [PW-1:0]       pick_idx;
    logic                pick_any;
    logic [DWIDTH-1:0]   pick_flit, owner_flit;
    logic                can_send;
    logic                hdr_accept, own_accept, timeout_hit, load_out;
    logic [NUM_REQ-1:0]  ready_c, grant_c;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (link.req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign can_send   = !link.out_valid || link.out_ready;
    assign pick_flit  = link.req_data[pick_idx*DWIDTH +: DWIDTH];
    assign owner_flit = link.req_data[owner*DWIDTH +: DWIDTH];

    always_comb begin
        state_nx    = state;
        ready_c     = '0;
        grant_c     = '0;
        hdr_accept  = 1'b0;
        own_accept  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (arb_enable && pick_any) begin
                    ready_c[pick_idx] = can_send;
                    hdr_accept        = can_send;
                    if (can_send) begin
                        grant_c = pick_grant;
                        if (pick_flit[LEN_LSB +: LEN_W] != '0)
                            state_nx = LOCKED;
                    end
                end
            end
            LOCKED: begin
                ready_c[owner] = can_send;
                grant_c[owner] = 1'b1;
                own_accept     = can_send && link.req_valid[owner];
                if (own_accept && remaining == LEN_W'(1)) begin
                    state_nx = IDLE;
                end else if (!own_accept && stall_cnt == SW'(TIMEOUT-1)) begin
                    timeout_hit = 1'b1;
                    state_nx    = DROP;
                end
            end
            DROP: begin
                // Sink the aborted packet's tail without touching the output.
                ready_c[owner] = 1'b1;
                grant_c[owner] = 1'b1;
                own_accept     = link.req_valid[owner];
                if (remaining == '0 || (own_accept && remaining == LEN_W'(1)))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign load_out       = hdr_accept || (state == LOCKED && own_accept);
    assign link.req_ready = ready_c & {NUM_REQ{ARESETn}};
    assign grant_onehot   = grant_c & {NUM_REQ{ARESETn}};
    assign busy           = (state != IDLE);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state          <= IDLE;
            ptr            <= PW'(NUM_REQ-1);
            owner          <= '0;
            remaining      <= '0;
            stall_cnt      <= '0;
            link.out_valid <= 1'b0;
            link.out_data  <= '0;
            timeout_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            timeout_err <= timeout_hit;

            if (load_out) begin
                link.out_data  <= hdr_accept ? pick_flit : owner_flit;
                link.out_valid <= 1'b1;
            end else if (link.out_ready) begin
                link.out_valid <= 1'b0;
            end

            if (hdr_accept) begin
                ptr       <= pick_idx;
                owner     <= pick_idx;
                remaining <= pick_flit[LEN_LSB +: LEN_W];
            end else if (own_accept) begin
                remaining <= remaining - LEN_W'(1);
            end

            if (state == LOCKED && !own_accept && !timeout_hit)
                stall_cnt <= stall_cnt + SW'(1);
            else
                stall_cnt <= '0;
        end
    end
endmodule

// File: doc/noc_egress_arbiter.md
# noc_egress_arbiter

Packet-atomic round-robin arbiter that shares a single 16-bit router output link among up to five flit sources: four spine ingress streams and the local NI injection stream. It sits between the router's per-port input FIFOs and one egress port. It adds valid/ready backpressure in place of an always-ready sink. A stalled packet owner is aborted by a timeout, and the rest of that packet is drained.

## Interface
Parameters:
- `NUM_REQ`, 5, number of requesters (index 0..3 = spine11..spine41, 4 = local NI)
- `DWIDTH`, 16, flit width
- `LEN_LSB`, 6, LSB of header body-length field
- `LEN_W`, 4, width of body-length field (0..15 body flits after header)
- `TIMEOUT`, 64, stalled-cycle limit while a packet owns the link (≥2)

Ports:
- `ACLK` in 1: clock
- `ARESETn` in 1: reset, asynchronous and active-low
- `arb_enable` in 1: permits new grants
- `req_data` in NUM_REQ*DWIDTH: flits, requester i at [i*DWIDTH +: DWIDTH]
- `req_valid` in NUM_REQ: flit valid per requester
- `req_ready` out NUM_REQ: flit accepted when valid&ready
- `out_data` out DWIDTH: registered egress flit
- `out_valid` out 1: egress valid
- `out_ready` in 1: egress sink ready
- `grant_onehot` out NUM_REQ: current owner, zero in IDLE
- `busy` out 1: state ≠ IDLE
- `timeout_err` out 1: one-cycle pulse on abort

## Operation
- Header flit format: dest = [15:10]; body length L = [LEN_LSB +: LEN_W]. The packet is 1+L flits.
- Output stage is one register. `can_send` = !out_valid | out_ready.
- States:
  - **IDLE**
    - When `arb_enable` is high and any `req_valid` is high, pick the first valid requester at or after index ptr+1, wrapping modulo NUM_REQ.
    - The picked requester's `req_ready` = `can_send` combinationally in the same cycle.
    - On header accept: ptr ← g, load `remaining` ← L, latch g as owner.
    - If L=0, stay in IDLE. Otherwise go to LOCKED.
  - **LOCKED**
    - Only the owner sees `req_ready` = `can_send`. All other `req_ready` are 0.
    - Each accepted flit decrements `remaining`. Accepting the flit with `remaining`=1 returns the block to IDLE.
  - **DROP**
    - Owner `req_ready` = 1. Accepted flits are discarded and not written to the output register.
    - `remaining` decrements per flit. At 0 the block returns to IDLE.
    - No timeout applies in DROP.
- Timeout: `stall_cnt` counts LOCKED cycles in which no owner flit is accepted, and clears on accept.
  - At `stall_cnt` = TIMEOUT-1 with no accept: pulse `timeout_err`, go to DROP.
  - An `out_ready`-caused stall also counts.
- `arb_enable` low blocks only new grants in IDLE. LOCKED and DROP run to completion.
- `grant_onehot`:
  - In LOCKED/DROP it shows the owner.
  - In IDLE it is combinational and equals the pick when a header is accepted that cycle, else 0.
- Reset (mid-operation included) forces IDLE:
  - ptr = NUM_REQ-1, so requester 0 is first.
  - `remaining`, `stall_cnt` = 0.
  - `out_valid`, `out_data`, `timeout_err` = 0.
  - All outputs are 0 during reset.
  - An in-flight packet is lost.

## Timing
- Latency: flit accepted at edge N appears on `out_data`/`out_valid` from cycle N+1.
- Throughput: 1 flit/cycle with `out_ready` high.
- A new header may be accepted in the cycle immediately after a tail accept, so back-to-back packets have no bubble.
- `out_data` holds while out_valid & !out_ready. No duplication or loss.
- `timeout_err` is registered: high for exactly the first DROP cycle.
- Simultaneous tail accept and new requester valid: the new requester is granted next cycle at the earliest.

## Structure
- Package `noc_arb_pkg` holds:
  - DWIDTH
  - header field positions: DEST_LSB=10, DEST_W=6, LEN_LSB, LEN_W
  - state enum {IDLE, LOCKED, DROP}
- Sub-module `rr_pick`: rotating priority encoder (req vector, ptr → one-hot grant, index, any), purely combinational.
- Counters: `remaining` (LEN_W bits), `stall_cnt` ($clog2(TIMEOUT) bits).

## Test plan
- Req2 sends 16'h1480 (dest 5, L=2), then 16'hAAAA and 16'h5555, with out_ready=1 → out shows 1480, AAAA, 5555 on consecutive cycles starting 1 cycle after header; grant_onehot=5'b00100 throughout; then IDLE.
- After reset, all five hold L=0 headers continuously → grants 0,1,2,3,4,0, one per cycle; out_valid stays high.
- Req1 owns an L=3 packet; req3 raises valid after the 2nd flit → req3 is blocked until req1's tail is accepted, then req3's header is accepted next cycle.
- out_ready low 4 cycles mid-packet → out_data is held; owner req_ready=0; the sequence after release is intact with no duplication.
- TIMEOUT=8; req0 sends header L=3, then valid=0 → after 8 stalled cycles timeout_err pulses once and the state is DROP; req0's next 3 flits never appear on the output; then req4's pending header is granted.
- ARESETn pulsed low mid-packet → out_valid, grant_onehot, busy are 0 immediately (asynchronous); after release, with req0 and req4 both valid, req0 is granted first.
